// File: rtl/voice_alloc.sv
// voice_alloc: round-robin note arbiter feeding a pool of oscillator voices.
// Define VOICE_STEAL_EN to reassign the oldest sounding voice when none is free.
module voice_alloc #(
  parameter int NUM_REQ = 2,
  parameter int NUM_VOICE = 4,
  parameter int DIV_W = 16,
  parameter int AGE_W = 20
) (
  input  logic                       clk48m,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_trigger,
  input  logic [NUM_REQ*DIV_W-1:0]   req_divider,
  input  logic [NUM_REQ-1:0]         req_dehold,
  output logic [NUM_VOICE*DIV_W-1:0] voice_divider,
  output logic [NUM_VOICE-1:0]       voice_gate,
  output logic [NUM_VOICE-1:0]       voice_start,
  output logic                       busy,
  output logic                       dropped
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int VI_W = NUM_VOICE > 1 ? $clog2(NUM_VOICE) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, ASSIGN} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] pend, trig_ok, pend_clr;
  logic [2*NUM_REQ-1:0] pend_rot;
  logic [DIV_W-1:0] pend_div [NUM_REQ];
  logic [ID_W-1:0] rr_ptr, win, win_n;
  logic [DIV_W-1:0] win_div;
  logic [VI_W-1:0] scan_idx, cand_idx;
  logic cand_ok, cand_free, take, grant, fire;
  logic [ID_W-1:0] owner [NUM_VOICE];
  logic [DIV_W-1:0] vdiv [NUM_VOICE];
  logic [AGE_W-1:0] age [NUM_VOICE];
  assign grant = state == IDLE && |pend;
  assign fire = state == ASSIGN && cand_ok;
  assign busy = state != IDLE || |pend;
  assign dropped = state == ASSIGN && !cand_ok;
  assign pend_rot = {pend, pend} >> rr_ptr;
  assign pend_clr = grant ? NUM_REQ'(1) << win_n : '0;
  always_comb begin
    trig_ok = '0;
    for (int i = 0; i < NUM_REQ; i++)
      trig_ok[i] = req_trigger[i] && req_divider[i*DIV_W +: DIV_W] != '0;
  end
  // descending walk so the requester closest to rr_ptr is written last and wins
  always_comb begin
    win_n = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (pend_rot[k]) win_n = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
  end
`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] cand_age;
  always_ff @(posedge clk48m or posedge rst)
    if (rst) cand_age <= '0;
    else if (state == SCAN && take) cand_age <= age[scan_idx];
  assign take = !cand_free && (!voice_gate[scan_idx] || !cand_ok || age[scan_idx] > cand_age);
`else
  assign take = !cand_free && !voice_gate[scan_idx];
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (|pend) state_n = SCAN;
      SCAN: if (scan_idx == VI_W'(NUM_VOICE - 1)) state_n = ASSIGN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      rr_ptr <= '0;
      win <= '0;
      win_div <= '0;
      scan_idx <= '0;
      cand_ok <= 1'b0;
      cand_free <= 1'b0;
      cand_idx <= '0;
      for (int i = 0; i < NUM_REQ; i++) pend_div[i] <= '0;
    end else begin
      state <= state_n;
      pend <= (pend & ~pend_clr) | trig_ok;
      for (int i = 0; i < NUM_REQ; i++)
        if (trig_ok[i]) pend_div[i] <= req_divider[i*DIV_W +: DIV_W];
      if (grant) begin
        win <= win_n;
        win_div <= pend_div[win_n];
        scan_idx <= '0;
        cand_ok <= 1'b0;
        cand_free <= 1'b0;
      end
      if (state == SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (take) begin
          cand_ok <= 1'b1;
          cand_free <= !voice_gate[scan_idx];
          cand_idx <= scan_idx;
        end
      end
      if (state == ASSIGN) rr_ptr <= win == ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
    end
  end
  // an assign on the same edge as a dehold of that voice keeps the gate high
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      voice_gate <= '0;
      voice_start <= '0;
      for (int v = 0; v < NUM_VOICE; v++) begin
        owner[v] <= '0;
        vdiv[v] <= '0;
        age[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICE; v++) begin
        voice_start[v] <= fire && cand_idx == VI_W'(v);
        if (fire && cand_idx == VI_W'(v)) begin
          owner[v] <= win;
          vdiv[v] <= win_div;
          age[v] <= '0;
          voice_gate[v] <= 1'b1;
        end else begin
          if (voice_gate[v] && age[v] != '1) age[v] <= age[v] + 1'b1;
          if (req_dehold[owner[v]]) voice_gate[v] <= 1'b0;
        end
      end
    end
  end
  for (genvar v = 0; v < NUM_VOICE; v++) begin : g_div
    assign voice_divider[v*DIV_W +: DIV_W] = vdiv[v];
  end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed and random checks of voice_alloc against a note-level reference model.
module tb_voice_alloc;
  localparam int NR = 2, NV = 4, DW = 16, AW = 20;
  localparam int AMAX = (1 << AW) - 1;
  logic clk48m = 1'b0, rst = 1'b1;
  logic [NR-1:0] req_trigger = '0, req_dehold = '0;
  logic [NR*DW-1:0] req_divider = '0;
  logic [NV*DW-1:0] voice_divider;
  logic [NV-1:0] voice_gate, voice_start;
  logic busy, dropped;
  int checks = 0, errors = 0;
  logic [NR-1:0] m_pend;
  logic [DW-1:0] m_pdiv [NR];
  int m_rr, m_t, m_win;
  logic [DW-1:0] m_wdiv;
  logic m_gate [NV];
  logic [DW-1:0] m_div [NV];
  int m_owner [NV], m_age [NV];
  logic s_gate [NV];
  int s_age [NV];
  logic [NV-1:0] m_start;
  logic m_drop;
  voice_alloc #(.NUM_REQ(NR), .NUM_VOICE(NV), .DIV_W(DW), .AGE_W(AW)) dut (
    .clk48m(clk48m), .rst(rst), .req_trigger(req_trigger), .req_divider(req_divider),
    .req_dehold(req_dehold), .voice_divider(voice_divider), .voice_gate(voice_gate),
    .voice_start(voice_start), .busy(busy), .dropped(dropped)
  );
  always #10 clk48m = ~clk48m;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_pend = '0;
    m_rr = 0;
    m_t = 0;
    m_win = 0;
    m_wdiv = '0;
    m_start = '0;
    m_drop = 1'b0;
    for (int i = 0; i < NR; i++) m_pdiv[i] = '0;
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0; m_div[v] = '0; m_owner[v] = 0; m_age[v] = 0;
      s_gate[v] = 1'b0; s_age[v] = 0;
    end
  endtask
  // free voice with the lowest index, else (stealing) the oldest, ties to the lower index
  function automatic int pick();
    int best = -1;
    for (int v = NV - 1; v >= 0; v--) if (!s_gate[v]) best = v;
    if (best >= 0) return best;
`ifdef VOICE_STEAL_EN
    for (int v = 0; v < NV; v++) if (best < 0 || s_age[v] > s_age[best]) best = v;
`endif
    return best;
  endfunction
  // one clock edge: arbitrate, snapshot one voice per cycle, then assign
  task automatic model_edge();
    int a = -1, w = -1;
    m_start = '0;
    if (m_t == 0) begin
      for (int k = 0; k < NR; k++) if (w < 0 && m_pend[(m_rr + k) % NR]) w = (m_rr + k) % NR;
      if (w >= 0) begin
        m_win = w; m_wdiv = m_pdiv[w]; m_pend[w] = 1'b0; m_t = 1;
      end
    end else if (m_t <= NV) begin
      s_gate[m_t-1] = m_gate[m_t-1]; s_age[m_t-1] = m_age[m_t-1]; m_t++;
    end else begin
      a = pick(); m_rr = (m_win + 1) % NR; m_t = 0;
    end
    for (int v = 0; v < NV; v++) begin
      if (v == a) begin
        m_gate[v] = 1'b1; m_age[v] = 0; m_owner[v] = m_win; m_div[v] = m_wdiv; m_start[v] = 1'b1;
      end else begin
        if (m_gate[v] && m_age[v] < AMAX) m_age[v]++;
        if (req_dehold[m_owner[v]]) m_gate[v] = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++)
      if (req_trigger[i] && req_divider[i*DW +: DW] != 0) begin
        m_pend[i] = 1'b1; m_pdiv[i] = req_divider[i*DW +: DW];
      end
    m_drop = m_t == NV + 1 && pick() < 0;
  endtask
  task automatic cmp_all();
    logic [NV*DW-1:0] d;
    logic [NV-1:0] g;
    for (int v = 0; v < NV; v++) begin d[v*DW +: DW] = m_div[v]; g[v] = m_gate[v]; end
    chk("gate", voice_gate, g);
    chk("divider", voice_divider, d);
    chk("start", voice_start, m_start);
    chk("busy", busy, m_t != 0 || |m_pend);
    chk("dropped", dropped, m_drop);
  endtask
  task automatic cyc();
    @(posedge clk48m);
    if (!rst) model_edge();
    #1 req_trigger = '0;
    req_dehold = '0;
    @(negedge clk48m);
    cmp_all();
  endtask
  task automatic trig(input int i, input logic [DW-1:0] d);
    req_trigger[i] = 1'b1;
    req_divider[i*DW +: DW] = d;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    #1 cmp_all();
    repeat (2) cyc();
    rst = 1'b0;
  endtask
  initial begin
    int nb, ns, nd;
    do_reset();
    chk("rst_gate", voice_gate, 0);
    chk("rst_div", voice_divider, 0);
    chk("rst_start", voice_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", dropped, 0);
    trig(0, 16'h1234);
    cyc();
    nb = busy;
    repeat (5) begin cyc(); nb += busy; end
    chk("t1_start_early", voice_start, 0);
    cyc();
    nb += busy;
    chk("t1_start", voice_start, 4'b0001);
    chk("t1_div0", voice_divider[15:0], 16'h1234);
    chk("t1_gate", voice_gate, 4'b0001);
    chk("t1_busy_cycles", nb, 6);
    do_reset();
    trig(0, 16'h0100);
    trig(1, 16'h0200);
    repeat (7) cyc();
    chk("t2_start_a", voice_start, 4'b0001);
    chk("t2_div0", voice_divider[15:0], 16'h0100);
    repeat (6) cyc();
    chk("t2_start_b", voice_start, 4'b0010);
    chk("t2_div1", voice_divider[31:16], 16'h0200);
    trig(0, 16'h0300);
    trig(1, 16'h0400);
    repeat (7) cyc();
    chk("t2_rr_req0_first", voice_start, 4'b0100);
    repeat (6) cyc();
    chk("t2_start_d", voice_start, 4'b1000);
    chk("t2_gate_full", voice_gate, 4'b1111);
    repeat (20) cyc();
    req_dehold[1] = 1'b1;
    cyc();
    chk("t3_dehold_gate", voice_gate, 4'b0101);
    trig(1, 16'h0777);
    repeat (7) cyc();
    chk("t3_reuse_start", voice_start, 4'b0010);
    chk("t3_reuse_div", voice_divider[31:16], 16'h0777);
    chk("t3_gate", voice_gate, 4'b0111);
    do_reset();
    for (int i = 0; i < NV; i++) begin trig(0, DW'(16'h0010 + i)); repeat (7) cyc(); end
    chk("t4_gate_full", voice_gate, 4'b1111);
    trig(1, 16'h0999);
    nd = 0;
    ns = 0;
    repeat (7) begin cyc(); nd += dropped; ns += (voice_start != 0); end
`ifdef VOICE_STEAL_EN
    chk("t4_steal_start", voice_start, 4'b0001);
    chk("t4_steal_div0", voice_divider[15:0], 16'h0999);
    chk("t4_no_drop", nd, 0);
`else
    chk("t4_drop_count", nd, 1);
    chk("t4_no_start", ns, 0);
    chk("t4_div_hold", voice_divider, 64'h0013_0012_0011_0010);
`endif
    chk("t4_gate_hold", voice_gate, 4'b1111);
    do_reset();
    trig(0, 16'h0000);
    nb = 0;
    repeat (4) begin cyc(); nb += busy; end
    chk("t5_div0_busy", nb, 0);
    trig(1, 16'h0321);
    cyc();
    cyc();
    trig(0, 16'h0AAA);
    cyc();
    trig(0, 16'h0BBB);
    cyc();
    ns = 0;
    repeat (14) begin cyc(); ns += voice_start[1]; end
    chk("t5_single_assign", ns, 1);
    chk("t5_latest_div", voice_divider[31:16], 16'h0BBB);
    chk("t5_first_div", voice_divider[15:0], 16'h0321);
    trig(0, 16'h0555);
    repeat (3) cyc();
    rst = 1'b1;
    m_reset();
    #1;
    chk("t5_rst_gate", voice_gate, 0);
    chk("t5_rst_div", voice_divider, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_start", voice_start, 0);
    repeat (2) cyc();
    rst = 1'b0;
    ns = 0;
    repeat (10) begin cyc(); ns += (voice_start != 0); end
    chk("t5_grant_aborted", ns, 0);
    do_reset();
    repeat (400) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0) trig(i, $urandom_range(0, 3) == 0 ? '0 : DW'($urandom));
        if ($urandom_range(0, 15) == 0) req_dehold[i] = 1'b1;
      end
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
